fetch_ctrl: RTL and testbench

- Producer side of the instruction fetch buffer. Generates word-aligned fetch addresses and issues read requests to instruction memory.
- Collects the in-order read responses into a small skid FIFO and delivers them to the fetch buffer as {ready, rdata, pc} beats, throttled by the buffer's stall.
- Handles redirects (branch/jump/trap) by driving the buffer's clear/align inputs and discarding stale in-flight responses.

---
 rtl/fetch_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_fetch_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: producer side of the instruction fetch buffer.
// Issues word-aligned read requests, collects in-order responses into a small
// skid FIFO and hands them to the fetch buffer as {ready, rdata, pc} beats.
// Redirects clear the buffer and drop any responses that were already in flight.
// Optional: define FETCH_PERF_EN to add the perf_fetch / perf_discard counters.
module fetch_ctrl #(
    parameter logic [31:0] START_ADDR = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        buf_stall,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        fb_ready,
    output logic [31:0] fb_rdata,
    output logic [31:0] fb_pc,
    output logic        fb_clear,
    output logic        fb_align
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetch,
    output logic [31:0] perf_discard
`endif
);

    localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1);
    localparam logic [31:0] START_WORD = START_ADDR & 32'hFFFF_FFFC;
    localparam logic [CNT_W:0] DEPTH_CNT = (CNT_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [31:0]      fetch_addr;
    logic [31:0]      rsp_pc;
    logic [31:0]      redirect_word;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] outstanding_next;
    logic [CNT_W-1:0] discard;
    logic [CNT_W-1:0] fifo_cnt;
    logic [CNT_W:0]   in_flight;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [31:0]      fifo_pc   [FIFO_DEPTH];
    logic [31:0]      fifo_data [FIFO_DEPTH];

    logic grant;
    logic rsp_valid;
    logic rsp_drop;
    logic rsp_push;
    logic pop;
    logic credit;

    assign redirect_word = redirect_pc & 32'hFFFF_FFFC;

    // A request is only issued while every response it could produce already
    // has a FIFO slot reserved, so the FIFO can never overflow.
    assign in_flight = {1'b0, outstanding} + {1'b0, fifo_cnt};
    assign credit    = in_flight < DEPTH_CNT;
    assign mem_req   = (state == RUN) & credit & ~fb_clear;
    assign grant     = mem_req & mem_gnt;

    // Address is only meaningful with mem_req; hold it at 0 otherwise so the
    // interface is quiet in reset and while idle.
    assign mem_addr  = mem_req ? fetch_addr : 32'h0;

    // A response with nothing outstanding is a protocol error and is ignored.
    assign rsp_valid = mem_rvalid & (outstanding != '0);
    assign rsp_drop  = rsp_valid & ((discard != '0) | redirect);
    assign rsp_push  = rsp_valid & ~rsp_drop;

    assign outstanding_next = outstanding + CNT_W'(grant) - CNT_W'(rsp_valid);

    // The beat shown during a redirect cycle is wiped by the following clear,
    // so the FIFO is flushed rather than popped.
    assign fb_ready = (fifo_cnt != '0) & ~buf_stall & ~fb_clear;
    assign pop      = fb_ready & ~redirect;
    assign fb_pc    = fb_ready ? fifo_pc[rd_ptr]   : 32'h0;
    assign fb_rdata = fb_ready ? fifo_data[rd_ptr] : 32'h0;

    // Next-state logic; a redirect overrides whatever the current state wants.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        state_next = state;
        unique case (state)
            INIT:    state_next = RUN;
            RUN:     state_next = RUN;
            DRAIN:   if (discard == '0) state_next = RUN;
            default: state_next = INIT;
        endcase
        if (redirect) begin
            state_next = (outstanding_next != '0) ? DRAIN : RUN;
        end
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        // NOTE: sequential state always uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (reset) begin
            state <= INIT;
        end else begin
            state <= state_next;
        end
    end

    // Fetch/response address, credit counters and the redirect clear pulse.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fetch_addr  <= START_WORD;
            rsp_pc      <= START_WORD;
            outstanding <= '0;
            discard     <= '0;
            fb_clear    <= 1'b0;
            fb_align    <= 1'b0;
        end else begin
            outstanding <= outstanding_next;
            fb_clear    <= redirect;
            fb_align    <= redirect & redirect_pc[1];
            if (redirect) begin
                fetch_addr <= redirect_word;
                rsp_pc     <= redirect_word;
                // Everything still in flight after this cycle belongs to the
                // old stream and must be dropped on return.
                discard    <= outstanding_next;
            end else begin
                if (grant) begin
                    fetch_addr <= fetch_addr + 32'd4;
                end
                if (rsp_push) begin
                    rsp_pc <= rsp_pc + 32'd4;
                end
                if (rsp_valid && (discard != '0)) begin
                    discard <= discard - CNT_W'(1);
                end
            end
        end
    end

    // Skid FIFO pointers and occupancy; a redirect empties it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            fifo_cnt <= '0;
        end else if (redirect) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (rsp_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            fifo_cnt <= fifo_cnt + CNT_W'(rsp_push) - CNT_W'(pop);
        end
    end

    // Skid FIFO storage. When full, a simultaneous push overwrites the head
    // slot only at the edge, after the head has been read out this cycle.
    always_ff @(posedge clock) begin
        // NOTE: the storage array has no reset; its contents are never visible
        // unless fifo_cnt says the slot was written.
        if (rsp_push) begin
            fifo_pc[wr_ptr]   <= rsp_pc;
            fifo_data[wr_ptr] <= mem_rdata;
        end
    end

`ifdef FETCH_PERF_EN
    // Wrapping event counters; only reset clears them, redirects do not.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            perf_fetch   <= 32'h0;
            perf_discard <= 32'h0;
        end else begin
            if (pop) begin
                perf_fetch <= perf_fetch + 32'd1;
            end
            if (rsp_drop) begin
                perf_discard <= perf_discard + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: randomized bench for fetch_ctrl with a queue-based reference
// model (outstanding requests with a stale mark, buffered beats) and an
// in-order memory responder.
module tb_fetch_ctrl;

    localparam logic [31:0] START = 32'h0000_0100;
    localparam int          DEPTH = 2;

    logic        clock       = 1'b0;
    logic        reset       = 1'b1;
    logic        redirect    = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        buf_stall   = 1'b0;
    logic        mem_gnt     = 1'b0;
    logic        mem_rvalid  = 1'b0;
    logic [31:0] mem_rdata   = 32'h0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        fb_ready;
    logic [31:0] fb_rdata;
    logic [31:0] fb_pc;
    logic        fb_clear;
    logic        fb_align;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch;
    logic [31:0] perf_discard;
`endif

    always #5 clock = ~clock;

    fetch_ctrl #(
        .START_ADDR (START),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .buf_stall   (buf_stall),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_gnt     (mem_gnt),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .fb_ready    (fb_ready),
        .fb_rdata    (fb_rdata),
        .fb_pc       (fb_pc),
        .fb_clear    (fb_clear),
        .fb_align    (fb_align)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetch  (perf_fetch),
        .perf_discard(perf_discard)
`endif
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%08h expected=0x%08h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state.
    typedef struct {
        logic [31:0] addr;
        bit          stale;
    } req_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } beat_t;

    req_t        pend[$];     // granted, not yet returned, in order
    beat_t       fifo_q[$];   // returned, not yet delivered
    logic [31:0] next_addr;
    bit          exp_clear;
    bit          exp_align;
    bit          init_pending;
    bit          prev_stale_zero;
    logic [31:0] exp_fetch;
    logic [31:0] exp_discard;

    // Stimulus knobs and scenario observations.
    int          gnt_pct   = 100;
    int          rsp_pct   = 100;
    int          stall_pct = 0;
    bit          spur_en   = 1'b0;
    bit          hit;
    bit          capture_first;
    logic [31:0] first_pc;
    bit          saw_300;

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A3C_0F96;
    endfunction

    // Check this cycle's outputs against the model, then apply this cycle's events.
    task automatic evaluate();
        int    stale;
        bit    exp_ready;
        bit    allowed;
        bit    must;
        beat_t b;
        req_t  r;
        if (reset) begin
            check("rst_mem_req",  32'(mem_req),  32'h0);
            check("rst_mem_addr", mem_addr,      32'h0);
            check("rst_fb_ready", 32'(fb_ready), 32'h0);
            check("rst_fb_rdata", fb_rdata,      32'h0);
            check("rst_fb_pc",    fb_pc,         32'h0);
            check("rst_fb_clear", 32'(fb_clear), 32'h0);
            check("rst_fb_align", 32'(fb_align), 32'h0);
`ifdef FETCH_PERF_EN
            check("rst_perf_fetch",   perf_fetch,   32'h0);
            check("rst_perf_discard", perf_discard, 32'h0);
`endif
            pend.delete();
            fifo_q.delete();
            next_addr       = START & 32'hFFFF_FFFC;
            exp_clear       = 1'b0;
            exp_align       = 1'b0;
            init_pending    = 1'b1;
            prev_stale_zero = 1'b1;
            exp_fetch       = 32'h0;
            exp_discard     = 32'h0;
        end else begin
            stale = 0;
            foreach (pend[i]) if (pend[i].stale) stale++;

            check("fb_clear", 32'(fb_clear), 32'(exp_clear));
            check("fb_align", 32'(fb_align), 32'(exp_align));
            exp_ready = (fifo_q.size() > 0) && !buf_stall && !exp_clear;
            check("fb_ready", 32'(fb_ready), 32'(exp_ready));
            if (exp_ready) begin
                b = fifo_q[0];
                check("fb_pc",    fb_pc,    b.pc);
                check("fb_rdata", fb_rdata, b.data);
            end else begin
                check("fb_pc_idle",    fb_pc,    32'h0);
                check("fb_rdata_idle", fb_rdata, 32'h0);
            end

            // Requests: forbidden without credit, in the first cycle after
            // reset, in a clear cycle or with stale responses pending; required
            // once the old stream has been fully drained for a cycle.
            allowed = !init_pending && !exp_clear && (stale == 0) &&
                      (pend.size() + fifo_q.size() < DEPTH);
            must    = allowed && prev_stale_zero;
            if (must)          check("mem_req_expected", 32'(mem_req), 32'h1);
            else if (!allowed) check("mem_req_forbidden", 32'(mem_req), 32'h0);
            if (mem_req)       check("mem_addr", mem_addr, next_addr);
`ifdef FETCH_PERF_EN
            check("perf_fetch",   perf_fetch,   exp_fetch);
            check("perf_discard", perf_discard, exp_discard);
`endif
            if (fb_ready && capture_first) begin
                first_pc      = fb_pc;
                capture_first = 1'b0;
            end
            if (fb_ready && (fb_pc[31:8] == 24'h000003)) saw_300 = 1'b1;

            // Apply events of this cycle.
            if (exp_ready && !redirect) begin
                void'(fifo_q.pop_front());
                exp_fetch++;
            end
            if (mem_rvalid && (pend.size() > 0)) begin
                r = pend.pop_front();
                if (r.stale || redirect) begin
                    exp_discard++;
                end else begin
                    b.pc   = r.addr;
                    b.data = data_of(r.addr);
                    fifo_q.push_back(b);
                end
            end
            if (mem_req && mem_gnt) begin
                r.addr  = next_addr;
                r.stale = 1'b0;
                pend.push_back(r);
                next_addr = next_addr + 32'd4;
            end
            if (redirect) begin
                foreach (pend[i]) pend[i].stale = 1'b1;
                fifo_q.delete();
                next_addr = redirect_pc & 32'hFFFF_FFFC;
                exp_clear = 1'b1;
                exp_align = redirect_pc[1];
            end else begin
                exp_clear = 1'b0;
                exp_align = 1'b0;
            end
            prev_stale_zero = (stale == 0);
            init_pending    = 1'b0;
        end
    endtask

    // One clock cycle: drive inputs after the rising edge, check on the falling edge.
    // redir_mode: 0 none, 1 redirect, 2 redirect only if req/gnt/rvalid coincide.
    task automatic cycle(input bit rst = 1'b0, input int redir_mode = 0,
                         input logic [31:0] rpc = 32'h0);
        @(posedge clock);
        #1;
        reset      = rst;
        buf_stall  = (int'($urandom_range(99)) < stall_pct);
        mem_gnt    = (int'($urandom_range(99)) < gnt_pct);
        mem_rvalid = 1'b0;
        mem_rdata  = $urandom;
        if (pend.size() > 0) begin
            if (int'($urandom_range(99)) < rsp_pct) begin
                mem_rvalid = 1'b1;
                mem_rdata  = data_of(pend[0].addr);
            end
        end else if (spur_en && ($urandom_range(7) == 0)) begin
            mem_rvalid = 1'b1;
        end
        redirect    = 1'b0;
        redirect_pc = rpc;
        #1;
        if (redir_mode == 1) begin
            redirect = 1'b1;
        end else if (redir_mode == 2 && mem_req && mem_gnt && mem_rvalid) begin
            redirect = 1'b1;
            hit      = 1'b1;
        end
        @(negedge clock);
        evaluate();
    endtask

    initial begin
`ifdef FETCH_PERF_EN
        logic [31:0] d0;
`endif
        bit          r_redir;
        bit          r_rst;
        saw_300       = 1'b0;
        capture_first = 1'b0;
        first_pc      = 32'h0;
        hit           = 1'b0;

        // Reset, then streaming with grant every cycle and 1-cycle responses.
        cycle(1'b1);
        cycle(1'b1);
        capture_first = 1'b1;
        repeat (12) cycle();
        check("first_beat_pc", first_pc, 32'h100);

        // Fetch buffer stalls for 6 cycles mid-stream.
        stall_pct = 100;
        repeat (6) cycle();
        stall_pct = 0;
        repeat (6) cycle();

        // Redirect to 0x202 with two requests outstanding.
        rsp_pct = 0;
        for (int i = 0; i < 10 && pend.size() < 2; i++) cycle();
        check("outstanding_before_redirect", 32'(pend.size()), 32'h2);
`ifdef FETCH_PERF_EN
        d0 = perf_discard;
`endif
        cycle(1'b0, 1, 32'h0000_0202);
        capture_first = 1'b1;
        rsp_pct = 100;
        repeat (10) cycle();
        check("first_pc_after_202", first_pc, 32'h200);
`ifdef FETCH_PERF_EN
        check("perf_discard_delta", perf_discard - d0, 32'h2);
`endif

        // Redirect coinciding with a response and a granted request.
        hit = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) cycle(1'b0, 2, 32'h0000_0500);
        check("coincident_redirect_seen", 32'(hit), 32'h1);
        repeat (8) cycle();

        // Back-to-back redirects while draining.
        rsp_pct = 0;
        for (int i = 0; i < 10 && pend.size() < 2; i++) cycle();
        saw_300 = 1'b0;
        cycle(1'b0, 1, 32'h0000_0300);
        cycle(1'b0, 1, 32'h0000_0400);
        capture_first = 1'b1;
        rsp_pct = 100;
        repeat (12) cycle();
        check("no_0x300_beat", 32'(saw_300), 32'h0);
        check("first_pc_after_400", first_pc, 32'h400);

        // Asynchronous reset mid-stream.
        repeat (3) cycle();
        cycle(1'b1);
        capture_first = 1'b1;
        repeat (10) cycle();
        check("first_pc_after_reset", first_pc, 32'h100);

        // Randomized traffic, stalls, redirects, resets and spurious responses.
        spur_en = 1'b1;
        for (int blk = 0; blk < 15; blk++) begin
            gnt_pct   = int'($urandom_range(30, 100));
            rsp_pct   = int'($urandom_range(20, 100));
            stall_pct = int'($urandom_range(0, 60));
            for (int i = 0; i < 200; i++) begin
                r_redir = ($urandom_range(99) < 4);
                r_rst   = ($urandom_range(499) == 0);
                cycle(r_rst, r_redir ? 1 : 0, $urandom & 32'hFFFF_FFFE);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Safety net against a hung run.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
